// File: rtl/eco_y_cmp_monitor.sv
// ---------------------------------------------------------------------------
// eco_y_cmp_monitor
//
// Purpose:
//   Checker placed downstream of the 5x5->3 gate-level ECO test netlists.
//   Every cycle, the golden netlist and the revised netlist receive the same
//   A/B vector. This block compares their 3-bit Y outputs. It counts the
//   accepted vectors and the mismatching ones, and captures the first failing
//   vector. The run result is reported as busy/done/pass.
//
// Handshake:
//   There is no backpressure. A vector is accepted on every rising clk edge
//   where the FSM is in RUN and in_valid=1. When in_valid=0, or when the FSM
//   is outside RUN, the vector inputs are ignored. A start is accepted only
//   in IDLE or DONE.
//
// Ports:
//   clk, rst     rising-edge clock; synchronous active-high reset
//   start        begin a run (honoured in IDLE/DONE only)
//   num_vec      vectors to check, latched on an accepted start
//   in_valid     in_a/in_b/y_gold/y_rev carry a vector this cycle
//   in_a, in_b   operands applied to both netlists (captured on first miss)
//   y_gold       Y of the original netlist
//   y_rev        Y of the revised netlist
//   busy         1 while in RUN
//   done         1 while in DONE (level)
//   pass         done with zero mismatches
//   vec_cnt      vectors accepted in the current/last run
//   mism_cnt     mismatching vectors, saturating at all ones
//   first_vld    first_a/first_b/first_diff hold valid data
//   first_a/b    operands of the first mismatch
//   first_diff   y_gold ^ y_rev of the first mismatch
//   state_dbg    current FSM state (0=IDLE, 1=RUN, 2=DONE) for checkers
// ---------------------------------------------------------------------------
module eco_y_cmp_monitor #(
  parameter int VW           = 16,
  parameter int CW           = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [VW-1:0] num_vec,
  input  logic          in_valid,
  input  logic [4:0]    in_a,
  input  logic [4:0]    in_b,
  input  logic [2:0]    y_gold,
  input  logic [2:0]    y_rev,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [VW-1:0] vec_cnt,
  output logic [CW-1:0] mism_cnt,
  output logic          first_vld,
  output logic [4:0]    first_a,
  output logic [4:0]    first_b,
  output logic [2:0]    first_diff,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [VW-1:0] tgt_q;
  logic [VW-1:0] vec_cnt_inc;
  logic          start_ok;
  logic          accept;
  logic          mism;
  logic          last_vec;
  logic          stop_now;

  // Shared decode used by both the FSM and the datapath.
  always_comb begin
    start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    accept      = (state_q == S_RUN) && in_valid;
    // With the case inequality, an X on either Y counts as a miss in simulation.
    mism        = (y_gold !== y_rev);
    vec_cnt_inc = vec_cnt + {{(VW-1){1'b0}}, 1'b1};
    // tgt_q >= 1 whenever we are in RUN, so vec_cnt < tgt_q and this cannot wrap.
    last_vec    = (vec_cnt_inc == tgt_q);
    stop_now    = last_vec || ((STOP_ON_FAIL != 0) && mism);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (num_vec == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (accept && stop_now) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the registered state
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    pass      = (state_q == S_DONE) && (mism_cnt == '0);
    state_dbg = state_q;
  end

  // Datapath: counters, target and first-mismatch capture
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q      <= '0;
      vec_cnt    <= '0;
      mism_cnt   <= '0;
      first_vld  <= 1'b0;
      first_a    <= '0;
      first_b    <= '0;
      first_diff <= '0;
    end else if (start_ok) begin
      tgt_q      <= num_vec;
      vec_cnt    <= '0;
      mism_cnt   <= '0;
      first_vld  <= 1'b0;
      first_a    <= '0;
      first_b    <= '0;
      first_diff <= '0;
    end else if (accept) begin
      vec_cnt <= vec_cnt_inc;
      if (mism && (mism_cnt != {CW{1'b1}})) begin
        mism_cnt <= mism_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
      if (mism && !first_vld) begin
        first_vld  <= 1'b1;
        first_a    <= in_a;
        first_b    <= in_b;
        first_diff <= y_gold ^ y_rev;
      end
    end
  end

endmodule

// File: tb/tb_eco_y_cmp_monitor.sv
// ---------------------------------------------------------------------------
// tb_eco_y_cmp_monitor
//
// The bench drives three instances from the same vector bus. Each instance
// has its own start line:
//   u0: default parameters
//   u1: CW=2, to exercise saturation
//   u2: STOP_ON_FAIL=1
//
// A behavioural run model is kept for each instance. On every falling edge,
// all outputs of every instance are checked against that model. Literal
// expectations worked out by hand from the scenarios pin the model itself.
// ---------------------------------------------------------------------------
module tb_eco_y_cmp_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [2:0]  start = '0;
  logic [15:0] num_vec = '0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_a = '0;
  logic [4:0]  in_b = '0;
  logic [2:0]  y_gold = '0;
  logic [2:0]  y_rev = '0;

  // ---------------- DUT outputs ----------------
  logic        busy0, done0, pass0, fv0;
  logic [15:0] vc0;
  logic [7:0]  mc0;
  logic [4:0]  fa0, fb0;
  logic [2:0]  fd0;
  logic [1:0]  st0;

  logic        busy1, done1, pass1, fv1;
  logic [15:0] vc1;
  logic [1:0]  mc1;
  logic [4:0]  fa1, fb1;
  logic [2:0]  fd1;
  logic [1:0]  st1;

  logic        busy2, done2, pass2, fv2;
  logic [15:0] vc2;
  logic [7:0]  mc2;
  logic [4:0]  fa2, fb2;
  logic [2:0]  fd2;
  logic [1:0]  st2;

  eco_y_cmp_monitor #(.VW(16), .CW(8), .STOP_ON_FAIL(0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .num_vec(num_vec),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .y_gold(y_gold), .y_rev(y_rev),
    .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vc0), .mism_cnt(mc0),
    .first_vld(fv0), .first_a(fa0), .first_b(fb0), .first_diff(fd0), .state_dbg(st0));

  eco_y_cmp_monitor #(.VW(16), .CW(2), .STOP_ON_FAIL(0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .num_vec(num_vec),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .y_gold(y_gold), .y_rev(y_rev),
    .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vc1), .mism_cnt(mc1),
    .first_vld(fv1), .first_a(fa1), .first_b(fb1), .first_diff(fd1), .state_dbg(st1));

  eco_y_cmp_monitor #(.VW(16), .CW(8), .STOP_ON_FAIL(1)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .num_vec(num_vec),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .y_gold(y_gold), .y_rev(y_rev),
    .busy(busy2), .done(done2), .pass(pass2), .vec_cnt(vc2), .mism_cnt(mc2),
    .first_vld(fv2), .first_a(fa2), .first_b(fb2), .first_diff(fd2), .state_dbg(st2));

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Run phase per instance: 0 = idle, 1 = running, 2 = finished.
  int m_phase[3], m_tgt[3], m_cnt[3], m_mism[3];
  int m_fv[3], m_fa[3], m_fb[3], m_fd[3];
  int m_max[3] = '{255, 3, 255};
  int m_sof[3] = '{0, 0, 1};
  bit model_live = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_phase[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0; m_mism[i] = 0;
        m_fv[i] = 0; m_fa[i] = 0; m_fb[i] = 0; m_fd[i] = 0;
      end else if (m_phase[i] != 1) begin
        if (start[i]) begin
          m_tgt[i] = int'(num_vec);
          m_cnt[i] = 0; m_mism[i] = 0;
          m_fv[i] = 0; m_fa[i] = 0; m_fb[i] = 0; m_fd[i] = 0;
          m_phase[i] = (num_vec == 0) ? 2 : 1;
        end
      end else if (in_valid) begin
        m_cnt[i] = m_cnt[i] + 1;
        if (y_gold !== y_rev) begin
          if (m_mism[i] < m_max[i]) m_mism[i] = m_mism[i] + 1;
          if (m_fv[i] == 0) begin
            m_fv[i] = 1;
            m_fa[i] = int'(in_a);
            m_fb[i] = int'(in_b);
            m_fd[i] = int'(y_gold ^ y_rev);
          end
          if (m_sof[i] != 0) m_phase[i] = 2;
        end
        if (m_cnt[i] == m_tgt[i]) m_phase[i] = 2;
      end
    end
    if (rst) model_live = 1'b1;
  end

  task automatic cmp_inst(input int i, input logic busy, input logic done, input logic pass,
                          input logic [15:0] vc, input logic [7:0] mc, input logic fv,
                          input logic [4:0] fa, input logic [4:0] fb, input logic [2:0] fd);
    chk($sformatf("u%0d.busy", i), 32'(busy), 32'(m_phase[i] == 1));
    chk($sformatf("u%0d.done", i), 32'(done), 32'(m_phase[i] == 2));
    chk($sformatf("u%0d.pass", i), 32'(pass), 32'((m_phase[i] == 2) && (m_mism[i] == 0)));
    chk($sformatf("u%0d.vec_cnt", i), 32'(vc), 32'(m_cnt[i]));
    chk($sformatf("u%0d.mism_cnt", i), 32'(mc), 32'(m_mism[i]));
    chk($sformatf("u%0d.first_vld", i), 32'(fv), 32'(m_fv[i]));
    chk($sformatf("u%0d.first_a", i), 32'(fa), 32'(m_fa[i]));
    chk($sformatf("u%0d.first_b", i), 32'(fb), 32'(m_fb[i]));
    chk($sformatf("u%0d.first_diff", i), 32'(fd), 32'(m_fd[i]));
  endtask

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_live) begin
      cmp_inst(0, busy0, done0, pass0, vc0, mc0, fv0, fa0, fb0, fd0);
      cmp_inst(1, busy1, done1, pass1, vc1, {6'b0, mc1}, fv1, fa1, fb1, fd1);
      cmp_inst(2, busy2, done2, pass2, vc2, mc2, fv2, fa2, fb2, fd2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int i, input logic [15:0] n);
    start[i] = 1'b1;
    num_vec  = n;
    step();
    start[i] = 1'b0;
  endtask

  task automatic send(input logic [4:0] a, input logic [4:0] b,
                      input logic [2:0] g, input logic [2:0] r);
    in_valid = 1'b1; in_a = a; in_b = b; y_gold = g; y_rev = r;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1;
    idle(2);
    chk("rst.done", 32'(done0), 32'd0);
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.vec_cnt", 32'(vc0), 32'd0);
    rst = 1'b0;
    idle(1);

    // 1: four clean vectors. in_valid is held high on the start cycle, and
    // that cycle must not count as a vector.
    in_valid = 1'b1; y_gold = 3'd6; y_rev = 3'd1;
    do_start(0, 16'd4);
    chk("t1.busy_after_start", 32'(busy0), 32'd1);
    chk("t1.start_no_accept", 32'(vc0), 32'd0);
    for (int k = 0; k < 4; k++) send(5'(k), 5'(k + 7), 3'(k), 3'(k));
    chk("t1.done", 32'(done0), 32'd1);
    chk("t1.pass", 32'(pass0), 32'd1);
    chk("t1.vec_cnt", 32'(vc0), 32'd4);
    chk("t1.mism_cnt", 32'(mc0), 32'd0);
    chk("t1.first_vld", 32'(fv0), 32'd0);
    send(5'd1, 5'd1, 3'd1, 3'd2);   // ignored in DONE
    chk("t1.done_holds", 32'(vc0), 32'd4);

    // 2: a single mismatch on vector 2
    do_start(0, 16'd3);
    send(5'h01, 5'h02, 3'b010, 3'b010);
    send(5'h03, 5'h10, 3'b101, 3'b100);
    chk("t2.busy_mid", 32'(busy0), 32'd1);
    send(5'h04, 5'h05, 3'b111, 3'b111);
    chk("t2.mism_cnt", 32'(mc0), 32'd1);
    chk("t2.first_a", 32'(fa0), 32'h03);
    chk("t2.first_b", 32'(fb0), 32'h10);
    chk("t2.first_diff", 32'(fd0), 32'b001);
    chk("t2.pass", 32'(pass0), 32'd0);
    chk("t2.done", 32'(done0), 32'd1);

    // 3: CW=2 saturation, with 5 mismatches out of 6
    do_start(1, 16'd6);
    send(5'd1, 5'd2, 3'd7, 3'd0);
    send(5'd3, 5'd4, 3'd1, 3'd0);
    idle(1);
    send(5'd5, 5'd6, 3'd2, 3'd0);
    send(5'd7, 5'd8, 3'd4, 3'd0);
    send(5'd9, 5'd9, 3'd3, 3'd3);
    send(5'd10, 5'd11, 3'd5, 3'd0);
    chk("t3.mism_sat", 32'(mc1), 32'd3);
    chk("t3.first_a", 32'(fa1), 32'd1);
    chk("t3.first_diff", 32'(fd1), 32'd7);
    chk("t3.done", 32'(done1), 32'd1);

    // 4: STOP_ON_FAIL instance halts on the third vector
    do_start(2, 16'd10);
    send(5'd1, 5'd1, 3'd2, 3'd2);
    send(5'd2, 5'd2, 3'd4, 3'd4);
    send(5'd3, 5'd3, 3'd6, 3'd7);
    chk("t4.done", 32'(done2), 32'd1);
    chk("t4.vec_cnt", 32'(vc2), 32'd3);
    send(5'd4, 5'd4, 3'd0, 3'd1);
    send(5'd5, 5'd5, 3'd0, 3'd0);
    chk("t4.ignored", 32'(vc2), 32'd3);
    chk("t4.mism", 32'(mc2), 32'd1);

    // 5: num_vec=0 finishes immediately; a start during RUN is ignored
    do_start(0, 16'd0);
    chk("t5.zero_done", 32'(done0), 32'd1);
    chk("t5.zero_pass", 32'(pass0), 32'd1);
    do_start(0, 16'd5);
    send(5'd2, 5'd3, 3'd1, 3'd1);
    do_start(0, 16'd1);             // ignored: still running with target 5
    chk("t5.start_ignored_busy", 32'(busy0), 32'd1);
    chk("t5.start_ignored_cnt", 32'(vc0), 32'd1);

    // 6: gaps leave the counts alone, and a reset mid-run clears everything
    idle(2);
    send(5'd6, 5'd7, 3'd1, 3'd5);
    idle(3);
    chk("t6.gap_cnt", 32'(vc0), 32'd2);
    chk("t6.gap_mism", 32'(mc0), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.rst_busy", 32'(busy0), 32'd0);
    chk("t6.rst_done", 32'(done0), 32'd0);
    chk("t6.rst_vec", 32'(vc0), 32'd0);
    chk("t6.rst_mism", 32'(mc0), 32'd0);
    chk("t6.rst_fv", 32'(fv0), 32'd0);
    chk("t6.rst_fa", 32'(fa0), 32'd0);
    chk("t6.rst_u1_mism", 32'(mc1), 32'd0);

    // short randomised-value run on u0 to exercise the model
    do_start(0, 16'd20);
    for (int k = 0; k < 20; k++) begin
      logic [2:0] g;
      g = 3'($urandom_range(0, 7));
      send(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), g,
           ($urandom_range(0, 3) == 0) ? ~g : g);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    chk("rand.done", 32'(done0), 32'd1);
    chk("rand.vec_cnt", 32'(vc0), 32'd20);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so that a stuck run still ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no end expected end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
